// File: rtl/traffic_pkg.sv
// Shared definitions for the crossroad traffic-light sequencer: phase codes,
// light encodings and default phase durations (BCD ticks).
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_NSG  = 3'd0,
    PH_NSY  = 3'd1,
    PH_RED1 = 3'd2,
    PH_EWG  = 3'd3,
    PH_EWY  = 3'd4,
    PH_RED2 = 3'd5,
    PH_EMG  = 3'd6
  } phase_e;

  typedef enum logic {
    SUB_LOAD = 1'b0,
    SUB_RUN  = 1'b1
  } sub_e;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  localparam logic [7:0] DEF_T_NSG = 8'h25;
  localparam logic [7:0] DEF_T_NSY = 8'h03;
  localparam logic [7:0] DEF_T_EWG = 8'h20;
  localparam logic [7:0] DEF_T_EWY = 8'h03;
  localparam logic [7:0] DEF_T_RED = 8'h02;

  // Normal rotation; leaving an emergency always goes through the RED2 clearance.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_NSG:  return PH_NSY;
      PH_NSY:  return PH_RED1;
      PH_RED1: return PH_EWG;
      PH_EWG:  return PH_EWY;
      PH_EWY:  return PH_RED2;
      PH_RED2: return PH_NSG;
      default: return PH_RED2;
    endcase
  endfunction

endpackage

// File: rtl/traffic_seq_ctrl.sv
// Phase sequencer: runs an external BCD counter pair as the phase timer and
// steps the lights through green/yellow/all-red with hold and emergency overrides.
module traffic_seq_ctrl
  import traffic_pkg::*;
#(
  parameter logic [7:0] T_NSG = DEF_T_NSG,
  parameter logic [7:0] T_NSY = DEF_T_NSY,
  parameter logic [7:0] T_EWG = DEF_T_EWG,
  parameter logic [7:0] T_EWY = DEF_T_EWY,
  parameter logic [7:0] T_RED = DEF_T_RED
) (
  input  logic       CP,
  input  logic       Rd,
  input  logic       tick,
  input  logic       hold,
  input  logic       emg,
  input  logic [7:0] cnt_Q,
  output logic       cnt_LD,
  output logic [7:0] cnt_D,
  output logic       cnt_EP,
  output logic       cnt_ET,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase
);

  phase_e     phase_reg, phase_next;
  sub_e       sub_reg, sub_next;
  logic [7:0] dur;
  logic       terminal;
  logic       emg_req;

  always_ff @(posedge CP) begin
    if (Rd) begin
      phase_reg <= PH_NSG;
      sub_reg   <= SUB_LOAD;
    end else begin
      phase_reg <= phase_next;
      sub_reg   <= sub_next;
    end
  end

  always_comb begin
    dur = 8'h00;
    case (phase_reg)
      PH_NSG:           dur = T_NSG;
      PH_NSY:           dur = T_NSY;
      PH_EWG:           dur = T_EWG;
      PH_EWY:           dur = T_EWY;
      PH_RED1, PH_RED2: dur = T_RED;
      default:          dur = 8'h00;
    endcase
  end

  // Plain equality: any out-of-range readback simply never terminates the phase.
  assign terminal = (sub_reg == SUB_RUN) && (phase_reg != PH_EMG) && (cnt_Q == dur);
  assign emg_req  = emg && (phase_reg != PH_EMG);

  always_comb begin
    phase_next = phase_reg;
    sub_next   = sub_reg;
    cnt_LD     = 1'b1;
    cnt_ET     = 1'b1;
    cnt_EP     = 1'b0;
    if (sub_reg == SUB_LOAD) begin
      cnt_LD   = 1'b0;
      cnt_ET   = 1'b0;
      sub_next = SUB_RUN;
    end else begin
      cnt_EP = tick && !hold && !terminal;
    end
    // Emergency pre-empts everything, including a pending terminal or hold.
    if (emg_req) begin
      phase_next = PH_EMG;
      sub_next   = SUB_LOAD;
    end else if (sub_reg == SUB_RUN && !hold) begin
      if (phase_reg == PH_EMG) begin
        if (!emg) begin
          phase_next = PH_RED2;
          sub_next   = SUB_LOAD;
        end
      end else if (terminal) begin
        phase_next = next_phase(phase_reg);
        sub_next   = SUB_LOAD;
      end
    end
  end

  always_comb begin
    ns_light = LIGHT_R;
    ew_light = LIGHT_R;
    case (phase_reg)
      PH_NSG:  ns_light = LIGHT_G;
      PH_NSY:  ns_light = LIGHT_Y;
      PH_EWG:  ew_light = LIGHT_G;
      PH_EWY:  ew_light = LIGHT_Y;
      default: begin
        ns_light = LIGHT_R;
        ew_light = LIGHT_R;
      end
    endcase
  end

  assign phase = phase_reg;
  assign cnt_D = 8'h00;

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Directed bench for traffic_seq_ctrl with a behavioural cascaded BCD counter
// pair standing in for the two decade counters of the parent design.
module tb_traffic_seq_ctrl;

  logic       CP;
  logic       Rd;
  logic       tick;
  logic       hold;
  logic       emg;
  logic [7:0] cnt_Q;
  logic       cnt_LD;
  logic [7:0] cnt_D;
  logic       cnt_EP;
  logic       cnt_ET;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;

  logic [3:0] units_reg;
  logic [3:0] tens_reg;

  int errors = 0;
  int checks = 0;

  int tr_phase[8];
  int tr_cnt[8];
  int tr_ns[8];
  int tr_ew[8];

  // T_NSG shortened to 12 so the bench also crosses the 09->10 carry quickly.
  traffic_seq_ctrl #(
    .T_NSG(8'h12),
    .T_NSY(8'h03),
    .T_EWG(8'h20),
    .T_EWY(8'h03),
    .T_RED(8'h02)
  ) dut (
    .CP(CP),
    .Rd(Rd),
    .tick(tick),
    .hold(hold),
    .emg(emg),
    .cnt_Q(cnt_Q),
    .cnt_LD(cnt_LD),
    .cnt_D(cnt_D),
    .cnt_EP(cnt_EP),
    .cnt_ET(cnt_ET),
    .ns_light(ns_light),
    .ew_light(ew_light),
    .phase(phase)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Units: sync load, counts on EP&ET; tens enabled by the units carry.
  always_ff @(posedge CP) begin
    if (!cnt_LD) begin
      units_reg <= cnt_D[3:0];
      tens_reg  <= cnt_D[7:4];
    end else if (cnt_EP && cnt_ET) begin
      units_reg <= (units_reg == 4'd9) ? 4'd0 : units_reg + 4'd1;
      if (units_reg == 4'd9)
        tens_reg <= (tens_reg == 4'd9) ? 4'd0 : tens_reg + 4'd1;
    end
  end
  assign cnt_Q = {tens_reg, units_reg};

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("check %s: got=%0h ok", tag, got);
    end
  endtask

  task automatic drive(input logic t);
    tick = t;
    #1;
  endtask

  task automatic adv;
    @(negedge CP);
  endtask

  function automatic int bcd(input int i);
    return ((i / 10) * 16) + (i % 10);
  endfunction

  task automatic run_until(input int p, input int q, input int budget);
    int c;
    c = 0;
    while (!(int'(phase) == p && int'(cnt_Q) == q) && c < budget) begin
      drive(c % 4 == 0);
      adv;
      c++;
    end
    check("run_until_in_budget", int'(c < budget), 1);
  endtask

  // Ticks every 4 cycles; records each completed phase, its counted ticks and lights.
  task automatic trace(input int nphases, input int budget);
    int c;
    int k;
    int ep_cnt;
    int cur;
    int last_ns;
    int last_ew;
    c = 0;
    k = 0;
    ep_cnt = 0;
    cur = int'(phase);
    last_ns = 0;
    last_ew = 0;
    while (k < nphases && c < budget) begin
      drive(c % 4 == 0);
      if (cnt_EP) ep_cnt++;
      last_ns = int'(ns_light);
      last_ew = int'(ew_light);
      adv;
      c++;
      if (int'(phase) != cur) begin
        tr_phase[k] = cur;
        tr_cnt[k]   = ep_cnt;
        tr_ns[k]    = last_ns;
        tr_ew[k]    = last_ew;
        k++;
        ep_cnt = 0;
        cur = int'(phase);
      end
    end
    check("trace_in_budget", int'(c < budget), 1);
  endtask

  int exp_cnt[6] = '{12, 3, 2, 20, 3, 2};
  int exp_ns[6]  = '{1, 2, 4, 4, 4, 4};
  int exp_ew[6]  = '{4, 4, 4, 1, 2, 4};

  initial begin
    int ep_seen;
    int off_emg;
    Rd = 1'b1;
    tick = 1'b1;
    hold = 1'b0;
    emg = 1'b1;
    adv;
    drive(1'b1);
    check("rst_phase", int'(phase), 0);
    check("rst_ld", int'(cnt_LD), 0);
    check("rst_ep", int'(cnt_EP), 0);
    check("rst_et", int'(cnt_ET), 0);
    check("rst_d", int'(cnt_D), 8'h00);
    check("rst_ns", int'(ns_light), 3'b001);
    check("rst_ew", int'(ew_light), 3'b100);

    // Timer run through NSG, one tick every 4 cycles
    Rd = 1'b0;
    emg = 1'b0;
    drive(1'b0);
    check("nsg_load_ld", int'(cnt_LD), 0);
    adv;
    check("nsg_run_ld", int'(cnt_LD), 1);
    check("nsg_run_q", int'(cnt_Q), 8'h00);
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1);
      check("nsg_tick_ep", int'(cnt_EP), 1);
      adv;
      check("nsg_q", int'(cnt_Q), bcd(i));
      if (i < 12) begin
        for (int j = 0; j < 3; j++) begin
          drive(1'b0);
          adv;
        end
      end
    end
    drive(1'b1);
    check("term_ep", int'(cnt_EP), 0);
    check("term_phase", int'(phase), 0);
    adv;
    check("nsy_phase", int'(phase), 1);
    check("nsy_ns", int'(ns_light), 3'b010);
    check("nsy_ew", int'(ew_light), 3'b100);
    check("nsy_load_ld", int'(cnt_LD), 0);
    drive(1'b1);
    check("load_tick_ep", int'(cnt_EP), 0);
    adv;
    check("nsy_run_q", int'(cnt_Q), 8'h00);
    check("nsy_run_ld", int'(cnt_LD), 1);

    // Finish the rotation, then one full cycle from NSG
    trace(5, 1000);
    for (int k = 0; k < 5; k++) begin
      check("rest_phase", tr_phase[k], k + 1);
      check("rest_cnt", tr_cnt[k], exp_cnt[k + 1]);
    end
    check("rest_end_phase", int'(phase), 0);
    trace(6, 2000);
    for (int k = 0; k < 6; k++) begin
      check("full_phase", tr_phase[k], k);
      check("full_cnt", tr_cnt[k], exp_cnt[k]);
      check("full_ns", tr_ns[k], exp_ns[k]);
      check("full_ew", tr_ew[k], exp_ew[k]);
    end
    check("full_end_phase", int'(phase), 0);

    // Hold in EWG at 12
    run_until(3, 8'h12, 2000);
    hold = 1'b1;
    ep_seen = 0;
    for (int c = 0; c < 40; c++) begin
      drive(c % 4 == 0);
      if (cnt_EP) ep_seen++;
      adv;
    end
    check("hold_ep_count", ep_seen, 0);
    check("hold_q", int'(cnt_Q), 8'h12);
    check("hold_phase", int'(phase), 3);
    hold = 1'b0;
    drive(1'b1);
    check("release_ep", int'(cnt_EP), 1);
    adv;
    check("release_q", int'(cnt_Q), 8'h13);

    // Emergency during NSG at 07
    run_until(0, 8'h07, 2000);
    emg = 1'b1;
    drive(1'b0);
    adv;
    check("emg_phase", int'(phase), 6);
    check("emg_ns", int'(ns_light), 3'b100);
    check("emg_ew", int'(ew_light), 3'b100);
    check("emg_ld", int'(cnt_LD), 0);
    off_emg = 0;
    for (int c = 0; c < 20; c++) begin
      drive(c % 4 == 0);
      adv;
      if (int'(phase) != 6) off_emg++;
    end
    check("emg_stays", off_emg, 0);
    emg = 1'b0;
    drive(1'b0);
    adv;
    check("emg_exit_phase", int'(phase), 5);
    check("emg_exit_ld", int'(cnt_LD), 0);
    trace(1, 500);
    check("red2_phase", tr_phase[0], 5);
    check("red2_cnt", tr_cnt[0], 2);
    check("red2_next", int'(phase), 0);

    // Reset during EWY with tick high
    run_until(4, 8'h01, 2000);
    Rd = 1'b1;
    drive(1'b1);
    adv;
    Rd = 1'b0;
    drive(1'b1);
    check("rd_phase", int'(phase), 0);
    check("rd_ld", int'(cnt_LD), 0);
    check("rd_ep", int'(cnt_EP), 0);
    check("rd_ns", int'(ns_light), 3'b001);
    check("rd_ew", int'(ew_light), 3'b100);
    adv;
    check("rd_run_q", int'(cnt_Q), 8'h00);
    check("rd_run_ld", int'(cnt_LD), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
